// File: rtl/ex_stage.sv
// ex_stage: forwarding, ALU and EX/MEM pipeline register with stall, flush and async active-low reset
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] d1_in,
   input  logic [15:0] d2_in,
   input  logic [15:0] imm_in,
   input  logic [2:0]  rs_in,
   input  logic [2:0]  rt_in,
   input  logic [2:0]  wreg_in,
   input  logic [2:0]  func_in,
   input  logic        rwrite_in,
   input  logic        mreg_in,
   input  logic        mread_in,
   input  logic        mwrite_in,
   input  logic        asrc_in,
   input  logic [1:0]  aluop_in,
   input  logic        stall,
   input  logic        flush,
   input  logic        wb_rwrite,
   input  logic [2:0]  wb_wreg,
   input  logic [15:0] wb_data,
   output logic [15:0] alu_out,
   output logic [15:0] sdata_out,
   output logic [2:0]  wreg_out,
   output logic        rwrite_out,
   output logic        mreg_out,
   output logic        mread_out,
   output logic        mwrite_out,
   output logic        zero_out
);
   logic [15:0] r_alu, r_sdata;
   logic [2:0]  r_wreg;
   logic        r_rwrite, r_mreg, r_mread, r_mwrite, r_zero;
   logic        w_exa, w_exb, w_wba, w_wbb;
   logic [15:0] w_a, w_b, w_fb, w_res;
   logic [2:0]  w_op;
   // a load in EX/MEM holds an address, not the loaded value, so it never forwards
   assign w_exa = r_rwrite && !r_mread && r_wreg != 3'd0 && r_wreg == rs_in;
   assign w_exb = r_rwrite && !r_mread && r_wreg != 3'd0 && r_wreg == rt_in;
   assign w_wba = wb_rwrite && wb_wreg != 3'd0 && wb_wreg == rs_in;
   assign w_wbb = wb_rwrite && wb_wreg != 3'd0 && wb_wreg == rt_in;
   assign w_a   = w_exa ? r_alu : w_wba ? wb_data : d1_in;
   assign w_fb  = w_exb ? r_alu : w_wbb ? wb_data : d2_in;
   assign w_b   = asrc_in ? imm_in : w_fb;
   assign w_op  = (aluop_in == 2'b10) ? func_in : (aluop_in == 2'b01) ? 3'd1 : 3'd0;
   always_comb begin
      case (w_op)
         3'd0:    w_res = w_a + w_b;
         3'd1:    w_res = w_a - w_b;
         3'd2:    w_res = w_a & w_b;
         3'd3:    w_res = w_a | w_b;
         3'd4:    w_res = w_a ^ w_b;
         3'd5:    w_res = {15'd0, $signed(w_a) < $signed(w_b)};
         3'd6:    w_res = w_a << w_b[3:0];
         default: w_res = w_a >> w_b[3:0];
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || flush) begin
         r_alu    <= '0;
         r_sdata  <= '0;
         r_wreg   <= '0;
         r_rwrite <= 1'b0;
         r_mreg   <= 1'b0;
         r_mread  <= 1'b0;
         r_mwrite <= 1'b0;
         r_zero   <= 1'b0;
      end else if (!stall) begin
         r_alu    <= w_res;
         r_sdata  <= w_fb;
         r_wreg   <= wreg_in;
         r_rwrite <= rwrite_in;
         r_mreg   <= mreg_in;
         r_mread  <= mread_in;
         r_mwrite <= mwrite_in;
         r_zero   <= ~|w_res;
      end
   end
   assign alu_out    = r_alu;
   assign sdata_out  = r_sdata;
   assign wreg_out   = r_wreg;
   assign rwrite_out = r_rwrite;
   assign mreg_out   = r_mreg;
   assign mread_out  = r_mread;
   assign mwrite_out = r_mwrite;
   assign zero_out   = r_zero;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: vector table, directed hazard/stall/reset sequences and random stimulus against a reference model
module tb_ex_stage;
   logic        clk = 1'b0, rst;
   logic [15:0] d1_in, d2_in, imm_in, wb_data;
   logic [2:0]  rs_in, rt_in, wreg_in, func_in, wb_wreg;
   logic        rwrite_in, mreg_in, mread_in, mwrite_in, asrc_in, stall, flush, wb_rwrite;
   logic [1:0]  aluop_in;
   logic [15:0] alu_out, sdata_out;
   logic [2:0]  wreg_out;
   logic        rwrite_out, mreg_out, mread_out, mwrite_out, zero_out;
   int total = 0, bad = 0;

   ex_stage dut (
      .clk(clk), .rst(rst), .d1_in(d1_in), .d2_in(d2_in), .imm_in(imm_in),
      .rs_in(rs_in), .rt_in(rt_in), .wreg_in(wreg_in), .func_in(func_in),
      .rwrite_in(rwrite_in), .mreg_in(mreg_in), .mread_in(mread_in), .mwrite_in(mwrite_in),
      .asrc_in(asrc_in), .aluop_in(aluop_in), .stall(stall), .flush(flush),
      .wb_rwrite(wb_rwrite), .wb_wreg(wb_wreg), .wb_data(wb_data),
      .alu_out(alu_out), .sdata_out(sdata_out), .wreg_out(wreg_out), .rwrite_out(rwrite_out),
      .mreg_out(mreg_out), .mread_out(mread_out), .mwrite_out(mwrite_out), .zero_out(zero_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int alu, sd, wr, rw, mr, mrd, mw, z;
   } st_t;
   st_t mdl;

   typedef struct {
      logic [15:0] d1, d2, imm;
      logic [2:0]  func;
      logic [1:0]  aluop;
      logic        asrc;
      logic [15:0] alu;
      logic        z;
   } vec_t;

   function automatic int fwd(int r, int d);
      if (mdl.rw == 1 && mdl.mrd == 0 && mdl.wr != 0 && mdl.wr == r) return mdl.alu;
      if (wb_rwrite && wb_wreg != 0 && int'(wb_wreg) == r) return int'(wb_data);
      return d;
   endfunction

   function automatic st_t model_next();
      st_t n;
      int a, fb, b, op, res;
      if (flush) begin
         n = '{0, 0, 0, 0, 0, 0, 0, 0};
         return n;
      end
      if (stall) return mdl;
      a  = fwd(int'(rs_in), int'(d1_in));
      fb = fwd(int'(rt_in), int'(d2_in));
      b  = asrc_in ? int'(imm_in) : fb;
      op = (aluop_in == 2) ? int'(func_in) : (aluop_in == 1) ? 1 : 0;
      case (op)
         0: res = (a + b) % 65536;
         1: res = (a - b + 65536) % 65536;
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         5: res = ((a >= 32768 ? a - 65536 : a) < (b >= 32768 ? b - 65536 : b)) ? 1 : 0;
         6: res = (a * (2 ** (b % 16))) % 65536;
         default: res = a / (2 ** (b % 16));
      endcase
      n.alu = res; n.sd = fb; n.wr = int'(wreg_in); n.rw = int'(rwrite_in);
      n.mr = int'(mreg_in); n.mrd = int'(mread_in); n.mw = int'(mwrite_in);
      n.z = (res == 0) ? 1 : 0;
      return n;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic cmp_all(input string tag);
      chk({tag, ".alu"}, int'(alu_out), mdl.alu);
      chk({tag, ".sdata"}, int'(sdata_out), mdl.sd);
      chk({tag, ".wreg"}, int'(wreg_out), mdl.wr);
      chk({tag, ".rwrite"}, int'(rwrite_out), mdl.rw);
      chk({tag, ".mreg"}, int'(mreg_out), mdl.mr);
      chk({tag, ".mread"}, int'(mread_out), mdl.mrd);
      chk({tag, ".mwrite"}, int'(mwrite_out), mdl.mw);
      chk({tag, ".zero"}, int'(zero_out), mdl.z);
   endtask

   task automatic step(input string tag);
      st_t n;
      n = model_next();
      @(posedge clk);
      #1;
      mdl = n;
      cmp_all(tag);
   endtask

   task automatic clr();
      {d1_in, d2_in, imm_in, wb_data} = '0;
      {rs_in, rt_in, wreg_in, func_in, wb_wreg, aluop_in} = '0;
      {rwrite_in, mreg_in, mread_in, mwrite_in, asrc_in, stall, flush, wb_rwrite} = '0;
   endtask

   task automatic instr(input logic [1:0] op, input logic [2:0] f, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [15:0] d1, input logic [15:0] d2, input logic [2:0] wr, input logic rw);
      aluop_in = op; func_in = f; rs_in = rs; rt_in = rt; d1_in = d1; d2_in = d2;
      wreg_in = wr; rwrite_in = rw;
   endtask

   vec_t tbl[$];

   initial begin
      tbl = '{
         '{16'h0005, 16'h0003, 16'h0000, 3'd0, 2'b10, 1'b0, 16'h0008, 1'b0},
         '{16'h0005, 16'h0005, 16'h0000, 3'd1, 2'b10, 1'b0, 16'h0000, 1'b1},
         '{16'hF0F0, 16'hFF00, 16'h0000, 3'd2, 2'b10, 1'b0, 16'hF000, 1'b0},
         '{16'hF0F0, 16'h0F0F, 16'h0000, 3'd3, 2'b10, 1'b0, 16'hFFFF, 1'b0},
         '{16'hFFFF, 16'h00FF, 16'h0000, 3'd4, 2'b10, 1'b0, 16'hFF00, 1'b0},
         '{16'hFFFF, 16'h0001, 16'h0000, 3'd5, 2'b10, 1'b0, 16'h0001, 1'b0},
         '{16'h0001, 16'hFFFF, 16'h0000, 3'd5, 2'b10, 1'b0, 16'h0000, 1'b1},
         '{16'h0001, 16'h0013, 16'h0000, 3'd6, 2'b10, 1'b0, 16'h0008, 1'b0},
         '{16'h8000, 16'h0004, 16'h0000, 3'd7, 2'b10, 1'b0, 16'h0800, 1'b0},
         '{16'h0007, 16'h1111, 16'hFFFF, 3'd5, 2'b00, 1'b1, 16'h0006, 1'b0},
         '{16'h0003, 16'h0005, 16'h0000, 3'd0, 2'b01, 1'b0, 16'hFFFE, 1'b0},
         '{16'hFFFF, 16'h0001, 16'h0000, 3'd1, 2'b11, 1'b0, 16'h0000, 1'b1}
      };
      clr();
      rst = 1'b0;
      mdl = '{0, 0, 0, 0, 0, 0, 0, 0};
      #2;
      cmp_all("reset");
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i]) begin
         instr(tbl[i].aluop, tbl[i].func, 3'd0, 3'd0, tbl[i].d1, tbl[i].d2, 3'd2, 1'b1);
         imm_in = tbl[i].imm; asrc_in = tbl[i].asrc;
         step($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.alu_const", i), int'(alu_out), int'(tbl[i].alu));
         chk($sformatf("tbl%0d.zero_const", i), int'(zero_out), int'(tbl[i].z));
         chk($sformatf("tbl%0d.sdata_const", i), int'(sdata_out), int'(tbl[i].d2));
      end
      clr();

      instr(2'b10, 3'd0, 3'd0, 3'd0, 16'h0005, 16'h0003, 3'd2, 1'b1);
      step("b2b1");
      chk("b2b1.alu_const", int'(alu_out), 16'h0008);
      instr(2'b01, 3'd0, 3'd2, 3'd0, 16'h0000, 16'h0001, 3'd5, 1'b1);
      step("b2b2");
      chk("b2b2.alu_const", int'(alu_out), 16'h0007);

      instr(2'b00, 3'd0, 3'd0, 3'd0, 16'h0010, 16'h0000, 3'd3, 1'b1);
      step("prio1");
      wb_rwrite = 1'b1; wb_wreg = 3'd3; wb_data = 16'h0020;
      instr(2'b00, 3'd0, 3'd3, 3'd0, 16'h0000, 16'h0000, 3'd1, 1'b0);
      asrc_in = 1'b1; imm_in = 16'h0000;
      step("prio2");
      chk("prio.alu_const", int'(alu_out), 16'h0010);
      step("wbfwd");
      chk("wbfwd.alu_const", int'(alu_out), 16'h0020);
      clr();

      instr(2'b00, 3'd0, 3'd0, 3'd0, 16'h0100, 16'h0000, 3'd4, 1'b1);
      mread_in = 1'b1;
      step("ld1");
      mread_in = 1'b0;
      instr(2'b00, 3'd0, 3'd4, 3'd0, 16'h0055, 16'h0000, 3'd1, 1'b1);
      step("ld2");
      chk("ld_nofwd.alu_const", int'(alu_out), 16'h0055);

      clr();
      wb_rwrite = 1'b1; wb_wreg = 3'd0; wb_data = 16'hFFFF;
      instr(2'b00, 3'd0, 3'd0, 3'd0, 16'h0001, 16'h1234, 3'd6, 1'b1);
      mwrite_in = 1'b1; mreg_in = 1'b1;
      step("r0");
      chk("r0.sdata_const", int'(sdata_out), 16'h1234);
      d1_in = 16'hAAAA; d2_in = 16'h5555; wreg_in = 3'd7; stall = 1'b1;
      step("stall1");
      step("stall2");
      chk("stall.sdata_const", int'(sdata_out), 16'h1234);
      flush = 1'b1;
      step("flush");
      chk("flush.alu_const", int'(alu_out), 0);
      clr();

      instr(2'b10, 3'd3, 3'd0, 3'd0, 16'h00F0, 16'h000F, 3'd5, 1'b1);
      step("pre_rst");
      #2;
      rst = 1'b0;
      #1;
      mdl = '{0, 0, 0, 0, 0, 0, 0, 0};
      cmp_all("async_rst");
      stall = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      cmp_all("rst_hold");
      clr();
      instr(2'b10, 3'd0, 3'd0, 3'd0, 16'h0001, 16'h0002, 3'd1, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      step("rst_release");
      chk("rst_release.alu_const", int'(alu_out), 16'h0003);

      for (int i = 0; i < 400; i++) begin
         d1_in = 16'($urandom); d2_in = 16'($urandom); imm_in = 16'($urandom);
         wb_data = 16'($urandom);
         rs_in = 3'($urandom_range(0, 3)); rt_in = 3'($urandom_range(0, 3));
         wreg_in = 3'($urandom_range(0, 3)); wb_wreg = 3'($urandom_range(0, 3));
         func_in = 3'($urandom); aluop_in = 2'($urandom);
         {rwrite_in, mreg_in, mwrite_in, asrc_in, wb_rwrite} = 5'($urandom);
         mread_in = ($urandom_range(0, 3) == 0);
         stall = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 15) == 0);
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have the following ports, one per line, as name, direction, width, meaning:
  clk  in  1  single clock; all state updates on rising edge
  rst  in  1  asynchronous, active-low reset
  d1_in, d2_in  in  16 each  register-file read data for rs and rt, from ID/EX
  imm_in  in  16  sign-extended immediate
  rs_in, rt_in  in  3 each  source register numbers
  wreg_in  in  3  destination register number
  func_in  in  3  R-type function code
  rwrite_in, mreg_in, mread_in, mwrite_in, asrc_in  in  1 each  write-back, mem-to-reg, load, store and ALU-B-source controls
  aluop_in  in  2  ALU operation class
  stall  in  1  hold EX/MEM register
  flush  in  1  insert bubble
  wb_rwrite  in  1  MEM/WB write enable
  wb_wreg  in  3  MEM/WB destination register
  wb_data  in  16  MEM/WB write-back value
  alu_out  out  16  registered ALU result
  sdata_out  out  16  registered store data
  wreg_out  out  3  registered destination register
  rwrite_out, mreg_out, mread_out, mwrite_out  out  1 each  registered controls
  zero_out  out  1  registered flag, high when the ALU result is zero

Function
REQ-002 Forward-A SHALL select, in priority order:
  - alu_out, when rwrite_out=1, mread_out=0, wreg_out!=0 and wreg_out==rs_in
  - wb_data, when wb_rwrite=1, wb_wreg!=0 and wb_wreg==rs_in
  - d1_in otherwise.
REQ-003 Forward-B SHALL use the same rule as REQ-002 with rt_in and d2_in.
REQ-004 Register 0 SHALL never be forwarded.
REQ-005 ALU operand A SHALL be Forward-A.
REQ-006 ALU operand B SHALL be imm_in when asrc_in=1, else Forward-B.
REQ-007 Store data SHALL always be Forward-B, regardless of asrc_in.
REQ-008 aluop_in SHALL select the operation: 00 ADD, 01 SUB, 11 ADD, 10 decoded from func_in.
REQ-009 func_in SHALL decode as: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
REQ-010 ADD and SUB SHALL wrap modulo 2^16, with no carry or overflow output.
REQ-011 SLT SHALL compare operands as signed and return 16'h0001 or 16'h0000.
REQ-012 SLL and SRL SHALL shift operand A by B[3:0], filling with zeros.
REQ-013 The zero flag SHALL be the combinational NOR of the 16-bit result.
REQ-014 On each rising clk with stall=0 and flush=0, all outputs SHALL load from the next-state values above; latency is 1 cycle.
REQ-015 With stall=1 and flush=0, all outputs SHALL hold their values.
REQ-016 With flush=1, all outputs SHALL load 0 on the next edge; flush takes priority over stall.
REQ-017 Forwarding SHALL use the pre-edge register values, so back-to-back dependent instructions resolve in the same cycle.
REQ-018 A load in EX/MEM (mread_out=1) SHALL NOT forward alu_out; the upstream hazard unit owns the load-use stall.

Reset
REQ-019 While rst=0, all outputs SHALL be 0 immediately, independent of clk.
REQ-020 Reset SHALL override stall and flush.
REQ-021 Release of rst SHALL take effect at the first rising clk with rst=1.
REQ-022 Reset asserted mid-operation SHALL discard the in-flight instruction.

Verification
REQ-023 R-type ADD: d1=0x0005, d2=0x0003, aluop=10, func=000, asrc=0, wreg=2, rwrite=1 -> next cycle alu_out=0x0008, wreg_out=2, rwrite_out=1, zero_out=0.
REQ-024 Back-to-back dependency: instruction 1 writes r2=0x0008. Instruction 2 has rs=2, d1=0x0000 (stale), d2=0x0001, SUB -> alu_out=0x0007.
REQ-025 Priority: EX/MEM holds r3=0x0010 and MEM/WB holds r3=0x0020. Next instruction has rs=3, ADD, B=0 -> alu_out=0x0010.
REQ-026 Register 0 and stall/flush:
  - wb_wreg=0, rt=0, d2=0x1234, wb_data=0xFFFF -> sdata_out=0x1234.
  - stall held 2 cycles -> outputs unchanged.
  - flush=1 with stall=1 -> all outputs 0.
REQ-027 SLT and shift:
  - SLT with A=0xFFFF, B=0x0001 -> 0x0001.
  - SLL with A=0x0001, B=0x0013 -> 0x0008.
  - SUB with equal operands -> zero_out=1.
REQ-028 Asynchronous reset: drive rst=0 between clock edges with non-zero outputs -> all outputs 0 at once. Release rst -> the first edge loads the applied inputs.
